// File: rtl/z16_mem_if.sv
// rtl/z16_mem_if.sv - shared instruction/data memory bus with req/ready handshake
//
// Purpose: one memory port carrying both instruction fetches and data
// loads/stores. A beat completes at the rising edge where req and ready
// are both high; address, write enable and write data stay stable from
// the first cycle of req until that edge.
//
// Signals:
//   req    master->slave  request valid
//   we     master->slave  1 = write (store), 0 = read (fetch/load)
//   addr   master->slave  byte address, ADDR_W bits
//   wdata  master->slave  store data
//   ready  slave->master  beat completes when req & ready
//   rdata  slave->master  read data, valid while ready is high
interface z16_mem_if #(
  parameter int ADDR_W = 16
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              ready;
  logic [15:0]       rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/z16_multicycle_cpu.sv
// rtl/z16_multicycle_cpu.sv - multi-cycle Z16 core on a single wait-state tolerant memory port
//
// Purpose: fetch/execute/memory sequencing for the Z16 core over one shared
// memory port, with a bus-timeout error state and a retire strobe.
//
// Instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2 or imm4.
//   0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SLT 8 SRA   (b = rs2)
//   9 ADDI  A LD rd,[rs1+imm4]  B ST [rs1+imm4],r[11:8]    (b = sext imm4)
//   C JAL   D JRL                                          (alu = rs1 + imm4)
//   E LHI rd <= {imm8, rd[7:0]}   F LLI rd <= imm8         (imm8 = ir[7:0])
//   r0 reads as zero and ignores writes.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous reset, active low
//   mem       memory bus master (req/we/addr/wdata out, ready/rdata in)
//   o_pc      current PC
//   o_retire  one-cycle pulse, one cycle after each retiring edge
//   o_err     bus timeout occurred; sticky until reset
module z16_multicycle_cpu #(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  z16_mem_if.master         mem,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_retire,
  output logic              o_err
);

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_ERR} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              retire_q, retire_d;
  // Held low through reset and its first clock so req never rises while
  // reset is asserted or on the release edge itself.
  logic              run_q;
  logic [15:0]       rf_q [16];

  logic [3:0]  op, rd, rs1, rs2;
  logic [15:0] imm, rs1_v, rs2_v, b, alu;
  logic        rd_wen, mem_wen, is_mem;
  logic        rf_we;
  logic [15:0] rf_wd;
  logic [15:0] pc_ext, pc_plus2;
  logic        timeout_hit;

  // Every PC value is truncated to ADDR_W and forced even.
  function automatic logic [ADDR_W-1:0] align(input logic [15:0] v);
    logic [ADDR_W-1:0] t;
    t    = v[ADDR_W-1:0];
    t[0] = 1'b0;
    return t;
  endfunction

  // Decoder: the store reuses the rd field as its data source register,
  // and LHI reads rd through the rs1 port to keep the low byte.
  always_comb begin
    op      = ir_q[15:12];
    rd      = ir_q[11:8];
    rs1     = (op == 4'hE) ? ir_q[11:8] : ir_q[7:4];
    rs2     = (op == 4'hB) ? ir_q[11:8] : ir_q[3:0];
    imm     = (op >= 4'hE) ? {8'h00, ir_q[7:0]} : {{12{ir_q[3]}}, ir_q[3:0]};
    rd_wen  = (op != 4'hB);
    mem_wen = (op == 4'hB);
    is_mem  = (op == 4'hA) || (op == 4'hB);
  end

  assign rs1_v = (rs1 == 4'd0) ? 16'h0000 : rf_q[rs1];
  assign rs2_v = (rs2 == 4'd0) ? 16'h0000 : rf_q[rs2];
  assign b     = (op <= 4'h8) ? rs2_v : imm;

  always_comb begin
    alu = rs1_v + b;
    case (op)
      4'h1:    alu = rs1_v - b;
      4'h2:    alu = rs1_v & b;
      4'h3:    alu = rs1_v | b;
      4'h4:    alu = rs1_v ^ b;
      4'h5:    alu = rs1_v << b[3:0];
      4'h6:    alu = rs1_v >> b[3:0];
      4'h7:    alu = {15'h0000, ($signed(rs1_v) < $signed(b))};
      4'h8:    alu = 16'($signed(rs1_v) >>> b[3:0]);
      4'hE:    alu = {b[7:0], rs1_v[7:0]};
      4'hF:    alu = b;
      default: alu = rs1_v + b;
    endcase
  end

  // PC arithmetic is done at 16 bits and truncated afterwards.
  assign pc_ext      = 16'(pc_q);
  assign pc_plus2    = pc_ext + 16'd2;
  assign timeout_hit = (TIMEOUT > 0) && (wcnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wcnt_d    = wcnt_q;
    retire_d  = 1'b0;
    rf_we     = 1'b0;
    rf_wd     = alu;
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = pc_q;
    mem.wdata = rs2_v;
    unique case (state_q)
      ST_FETCH: begin
        mem.req = run_q;
        if (run_q) begin
          if (mem.ready) begin
            ir_d    = mem.rdata;
            wcnt_d  = 16'd0;
            state_d = ST_EXEC;
          end else if (timeout_hit) begin
            state_d = ST_ERR;
          end else begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end
      end
      ST_EXEC: begin
        if (is_mem) begin
          state_d = ST_MEM;
        end else begin
          retire_d = 1'b1;
          state_d  = ST_FETCH;
          rf_we    = rd_wen;
          pc_d     = align(pc_plus2);
          if (op == 4'hC) begin
            rf_wd = pc_plus2;
            pc_d  = align(alu);
          end else if (op == 4'hD) begin
            rf_wd = pc_plus2;
            pc_d  = align(pc_ext + alu);
          end
        end
      end
      ST_MEM: begin
        // Address comes from IR and registers, which cannot change while
        // the beat is pending, so it is stable without a separate latch.
        mem.req  = 1'b1;
        mem.we   = mem_wen;
        mem.addr = alu[ADDR_W-1:0];
        if (mem.ready) begin
          rf_we    = !mem_wen;
          rf_wd    = mem.rdata;
          pc_d     = align(pc_plus2);
          retire_d = 1'b1;
          wcnt_d   = 16'd0;
          state_d  = ST_FETCH;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= align(RESET_PC);
      ir_q     <= 16'h0000;
      wcnt_q   <= 16'd0;
      retire_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      wcnt_q   <= wcnt_d;
      retire_q <= retire_d;
      run_q    <= 1'b1;
    end
  end

  // Register file keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (rf_we && (rd != 4'd0)) begin
      rf_q[rd] <= rf_wd;
    end
  end

  assign o_pc     = pc_q;
  assign o_retire = retire_q;
  assign o_err    = (state_q == ST_ERR);

endmodule

// File: tb/tb_z16_multicycle_cpu.sv
// tb/tb_z16_multicycle_cpu.sv - scoreboard bench for z16_multicycle_cpu
module tb_z16_multicycle_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst2_n;
  z16_mem_if #(.ADDR_W(16)) bus  ();
  z16_mem_if #(.ADDR_W(8))  bus2 ();
  logic [15:0] pc;
  logic [7:0]  pc2;
  logic        retire, err, retire2, err2;

  z16_multicycle_cpu #(.ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .mem(bus.master),
    .o_pc(pc), .o_retire(retire), .o_err(err));

  z16_multicycle_cpu #(.ADDR_W(8), .RESET_PC(16'h00FE), .TIMEOUT(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .mem(bus2.master),
    .o_pc(pc2), .o_retire(retire2), .o_err(err2));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- memories ----------------
  logic [15:0] mem  [0:1023];
  logic [15:0] mem2 [0:127];

  task automatic put(input logic [15:0] a, input logic [15:0] v);
    mem[a[10:1]] = v;
  endtask

  // ---------------- expected tables ----------------
  typedef struct packed { logic [15:0] pc; logic [15:0] cpi; } rexp_t;
  rexp_t       exp_ret[$];
  logic [31:0] exp_wr[$];

  logic [15:0] ret_pc_tab [0:22] = '{16'h02, 16'h04, 16'h06, 16'h08, 16'h0A, 16'h0C,
                                     16'h0E, 16'h10, 16'h40, 16'h3C, 16'h3E, 16'h20,
                                     16'h22, 16'h24, 16'h26, 16'h28, 16'h2A, 16'h2C,
                                     16'h2E, 16'h30, 16'h32, 16'h34, 16'h34};
  bit          ret_mem_tab [0:22] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0,
                                      0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0};
  logic [31:0] wr_tab [0:5] = '{32'h0080_000C, 32'h0084_1234, 32'h0104_BEEF,
                                32'h0086_0012, 32'h007E_0042, 32'h0087_4118};

  task automatic push_exp(input int f, input int m);
    rexp_t r;
    exp_ret.delete();
    exp_wr.delete();
    for (int i = 0; i < 23; i++) begin
      r.pc  = ret_pc_tab[i];
      r.cpi = (i == 0) ? 16'd0 : (ret_mem_tab[i] ? 16'(3 + f + m) : 16'(2 + f));
      exp_ret.push_back(r);
    end
    for (int i = 0; i < 6; i++) exp_wr.push_back(wr_tab[i]);
  endtask

  // ---------------- wait-state slave ----------------
  int fw = 0, mw = 0;
  bit hold_low = 0;
  int wcnt = 0;
  bit in_mem = 0;

  always @(negedge clk) begin
    bus.ready = 1'b0;
    bus.rdata = 16'h0000;
    if (rst_n && bus.req && !hold_low && (wcnt >= (in_mem ? mw : fw))) begin
      bus.ready = 1'b1;
      bus.rdata = mem[bus.addr[10:1]];
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      wcnt   = 0;
      in_mem = 0;
    end else if (bus.req && bus.ready) begin
      if (bus.we) mem[bus.addr[10:1]] = bus.wdata;
      if (!in_mem) in_mem = (bus.rdata[15:12] == 4'hA) || (bus.rdata[15:12] == 4'hB);
      else         in_mem = 0;
      wcnt = 0;
    end else if (bus.req) begin
      wcnt++;
    end
  end

  assign bus2.ready = 1'b1;
  assign bus2.rdata = mem2[bus2.addr[7:1]];

  // ---------------- monitor ----------------
  int          cyc = 0, last_ret = 0;
  bit          seen_ret = 0, pend = 0, h_we = 0;
  logic [15:0] h_addr = '0, h_wdata = '0;

  always @(negedge clk) begin
    rexp_t e;
    logic [31:0] w;
    #1;
    cyc++;
    if (!rst_n) begin
      seen_ret = 0;
      pend     = 0;
    end else begin
      if (pend && bus.req) begin
        chk("hold_addr", 32'(bus.addr), 32'(h_addr));
        chk("hold_we", 32'(bus.we), 32'(h_we));
        if (h_we) chk("hold_wdata", 32'(bus.wdata), 32'(h_wdata));
      end
      pend    = bus.req && !bus.ready;
      h_addr  = bus.addr;
      h_we    = bus.we;
      h_wdata = bus.wdata;
      if (bus.req && bus.ready && bus.we) begin
        chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          chk("write_addr", 32'(bus.addr), 32'(w[31:16]));
          chk("write_data", 32'(bus.wdata), 32'(w[15:0]));
        end
      end
      if (retire && exp_ret.size() != 0) begin
        e = exp_ret.pop_front();
        chk("retire_pc", 32'(pc), 32'(e.pc));
        if (seen_ret && e.cpi != 0) chk("cpi", 32'(cyc - last_ret), 32'(e.cpi));
        seen_ret = 1;
        last_ret = cyc;
      end
    end
  end

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_ret.size() != 0 || exp_wr.size() != 0) && k < 3000) begin
      step();
      k++;
    end
    chk(name, 32'(exp_ret.size() + exp_wr.size()), 32'd0);
  endtask

  task automatic run_phase(input int f, input int m, input string name);
    @(negedge clk);
    rst_n = 1'b0;
    fw = f;
    mw = m;
    push_exp(f, m);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int nf;
    bit got_wr;
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 128; i++) mem2[i] = 16'h0000;
    put(16'h00, 16'hF205); put(16'h02, 16'hF307); put(16'h04, 16'h0123);
    put(16'h06, 16'hF480); put(16'h08, 16'hB140); put(16'h0A, 16'hA542);
    put(16'h0C, 16'hB544); put(16'h0E, 16'hF641); put(16'h10, 16'hC760);
    put(16'h40, 16'hD80C); put(16'h3C, 16'hF920); put(16'h3E, 16'hC090);
    put(16'h20, 16'hF100); put(16'h22, 16'hE101); put(16'h24, 16'hF2EF);
    put(16'h26, 16'hE2BE); put(16'h28, 16'hB214); put(16'h2A, 16'hB746);
    put(16'h2C, 16'hB84E); put(16'h2E, 16'h1A32); put(16'h30, 16'hBA47);
    put(16'h32, 16'hFB34); put(16'h34, 16'hC0B0); put(16'h82, 16'h1234);
    mem2[7'h7F] = 16'hF15A;
    mem2[7'h00] = 16'hB106;
    #1;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    repeat (2) step();
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0000);

    run_phase(0, 0, "drain_zero_wait");
    run_phase(3, 2, "drain_wait_states");

    // Timeout: ready never arrives in FETCH.
    @(negedge clk);
    rst_n = 1'b0;
    hold_low = 1;
    exp_ret.delete();
    exp_wr.delete();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!bus.req && k < 10) begin step(); k++; end
    chk("to_req_seen", 32'(bus.req), 32'd1);
    k = 0;
    while (bus.req && k < 20) begin step(); k++; end
    chk("to_wait_cycles", 32'(k), 32'd4);
    chk("to_err", 32'(err), 32'd1);
    chk("to_req_low", 32'(bus.req), 32'd0);
    repeat (5) step();
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_req_stays_low", 32'(bus.req), 32'd0);
    chk("to_no_retire", 32'(retire), 32'd0);

    // Async reset while a store beat is pending, then restart.
    @(negedge clk);
    rst_n = 1'b0;
    hold_low = 0;
    fw = 0;
    mw = 3;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!(bus.req && bus.we) && k < 200) begin step(); k++; end
    chk("mid_mem_reached", 32'(bus.req && bus.we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_drops_req", 32'(bus.req), 32'd0);
    push_exp(0, 3);
    repeat (2) step();
    chk("rst_hold_req", 32'(bus.req), 32'd0);
    chk("rst_hold_err", 32'(err), 32'd0);
    chk("rst_hold_pc", 32'(pc), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (!bus.req && k < 10) begin step(); k++; end
    chk("restart_addr", 32'(bus.addr), 32'h0000);
    chk("restart_we", 32'(bus.we), 32'd0);
    wait_drain("drain_after_reset");

    // ADDR_W=8 core: PC wraps from 0xFE to 0x00.
    chk("w_rst_pc", 32'(pc2), 32'h00FE);
    chk("w_rst_req", 32'(bus2.req), 32'd0);
    @(negedge clk);
    rst2_n = 1'b1;
    nf = 0;
    got_wr = 0;
    for (int i = 0; i < 40 && !got_wr; i++) begin
      step();
      if (bus2.req && !bus2.we) begin
        if (nf == 0) chk("w_fetch0", 32'(bus2.addr), 32'h00FE);
        if (nf == 1) chk("w_fetch1", 32'(bus2.addr), 32'h0000);
        nf++;
      end
      if (bus2.req && bus2.we) begin
        chk("w_store_addr", 32'(bus2.addr), 32'h0006);
        chk("w_store_data", 32'(bus2.wdata), 32'h005A);
        got_wr = 1;
      end
    end
    chk("w_store_seen", 32'(got_wr), 32'd1);
    step();
    chk("w_pc_after_store", 32'(pc2), 32'h0002);
    chk("w_retire_after_store", 32'(retire2), 32'd1);
    chk("w_err", 32'(err2), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
